// File: rtl/fc_layer_engine.sv
// Fully-connected layer inference engine: streams N_IN unsigned samples, MACs them against
// N_OUT weight rows in parallel, adds biases and reports the argmax. Define FC_RELU_EN to clamp scores at 0.
module fc_layer_engine #(
  parameter int N_IN  = 784,
  parameter int N_OUT = 10,
  parameter int X_W   = 8,
  parameter int W_W   = 10,
  parameter int ACC_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic                       wr_sel,
  input  logic [$clog2(N_OUT)-1:0]   wr_row,
  input  logic [$clog2(N_IN)-1:0]    wr_col,
  input  logic signed [W_W-1:0]      wr_data,
  input  logic                       start,
  input  logic                       x_valid,
  input  logic [X_W-1:0]             x_data,
  output logic                       x_ready,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(N_OUT)-1:0]   result,
  output logic                       result_valid,
  output logic signed [ACC_W-1:0]    max_value
);
  localparam int ROW_W = $clog2(N_OUT);
  localparam int COL_W = $clog2(N_IN);
  localparam int P_W   = X_W + W_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_BIAS, S_SCAN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q [N_OUT];
  logic signed [ACC_W-1:0]   acc_d [N_OUT];
  logic [COL_W-1:0]          in_idx_q, in_idx_d;
  logic [ROW_W-1:0]          scan_idx_q, scan_idx_d;
  logic signed [ACC_W-1:0]   best_val_q, best_val_d;
  logic [ROW_W-1:0]          best_idx_q, best_idx_d;
  logic [ROW_W-1:0]          result_q, result_d;
  logic signed [ACC_W-1:0]   max_value_q, max_value_d;
  logic                      result_valid_q, result_valid_d;
  logic                      done_q, done_d;

  // Parameter storage deliberately has no reset so a loaded model survives rst_n.
  logic signed [W_W-1:0]     w_mem_q [N_OUT][N_IN];
  logic signed [W_W-1:0]     b_mem_q [N_OUT];
  logic                      w_we, b_we;
  logic signed [ACC_W-1:0]   scan_score;

  function automatic logic signed [ACC_W-1:0] mac_term(input logic [X_W-1:0] x,
                                                      input logic signed [W_W-1:0] w);
    logic signed [X_W:0] xs;
    logic signed [P_W-1:0] p;
    xs = signed'({1'b0, x});
    p  = P_W'(xs) * P_W'(w);
    return ACC_W'(p);
  endfunction

  function automatic logic signed [ACC_W-1:0] score_fn(input logic signed [ACC_W-1:0] a);
`ifdef FC_RELU_EN
    return a[ACC_W-1] ? '0 : a;
`else
    return a;
`endif
  endfunction

  assign w_we = wr_en && (state_q == S_IDLE) && !wr_sel &&
                (int'(wr_row) < N_OUT) && (int'(wr_col) < N_IN);
  assign b_we = wr_en && (state_q == S_IDLE) && wr_sel && (int'(wr_row) < N_OUT);

  always_ff @(posedge clk) begin
    if (w_we) w_mem_q[wr_row][wr_col] <= wr_data;
    if (b_we) b_mem_q[wr_row] <= wr_data;
  end

  assign scan_score = score_fn(acc_q[scan_idx_q]);

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    in_idx_d       = in_idx_q;
    scan_idx_d     = scan_idx_q;
    best_val_d     = best_val_q;
    best_idx_d     = best_idx_q;
    result_d       = result_q;
    max_value_d    = max_value_q;
    result_valid_d = result_valid_q;
    done_d         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int j = 0; j < N_OUT; j++) acc_d[j] = '0;
          in_idx_d       = '0;
          result_valid_d = 1'b0;
          state_d        = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (x_valid) begin
          for (int j = 0; j < N_OUT; j++)
            acc_d[j] = acc_q[j] + mac_term(x_data, w_mem_q[j][in_idx_q]);
          if (in_idx_q == COL_W'(N_IN - 1)) state_d = S_BIAS;
          else                              in_idx_d = in_idx_q + COL_W'(1);
        end
      end
      S_BIAS: begin
        for (int j = 0; j < N_OUT; j++) acc_d[j] = acc_q[j] + ACC_W'(b_mem_q[j]);
        scan_idx_d = '0;
        state_d    = S_SCAN;
      end
      S_SCAN: begin
        // Strict greater-than keeps the earliest index on ties.
        if (scan_idx_q == '0 || scan_score > best_val_q) begin
          best_val_d = scan_score;
          best_idx_d = scan_idx_q;
        end
        if (scan_idx_q == ROW_W'(N_OUT - 1)) state_d = S_DONE;
        else                                 scan_idx_d = scan_idx_q + ROW_W'(1);
      end
      S_DONE: begin
        result_d       = best_idx_q;
        max_value_d    = best_val_q;
        result_valid_d = 1'b1;
        done_d         = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      for (int j = 0; j < N_OUT; j++) acc_q[j] <= '0;
      in_idx_q       <= '0;
      scan_idx_q     <= '0;
      best_val_q     <= '0;
      best_idx_q     <= '0;
      result_q       <= '0;
      max_value_q    <= '0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      in_idx_q       <= in_idx_d;
      scan_idx_q     <= scan_idx_d;
      best_val_q     <= best_val_d;
      best_idx_q     <= best_idx_d;
      result_q       <= result_d;
      max_value_q    <= max_value_d;
      result_valid_q <= result_valid_d;
      done_q         <= done_d;
    end
  end

  assign x_ready      = (state_q == S_ACCUM);
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign result       = result_q;
  assign max_value    = max_value_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_fc_layer_engine.sv
// Self-checking bench for fc_layer_engine (N_IN=4, N_OUT=3) against a dot-product/argmax model.
module tb_fc_layer_engine;
  localparam int N_IN = 4, N_OUT = 3, X_W = 8, W_W = 10, ACC_W = 32;
  localparam int LAT = N_OUT + 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic wr_en = 1'b0, wr_sel = 1'b0;
  logic [1:0] wr_row = '0, wr_col = '0;
  logic signed [W_W-1:0] wr_data = '0;
  logic start = 1'b0, x_valid = 1'b0;
  logic [X_W-1:0] x_data = '0;
  logic x_ready, busy, done, result_valid;
  logic [1:0] result;
  logic signed [ACC_W-1:0] max_value;

  fc_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .X_W(X_W), .W_W(W_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data(wr_data), .start(start), .x_valid(x_valid), .x_data(x_data),
    .x_ready(x_ready), .busy(busy), .done(done), .result(result),
    .result_valid(result_valid), .max_value(max_value));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int mw[N_OUT][N_IN];
  int mb[N_OUT];
  typedef int vec_t[N_IN];

  function automatic void model(input vec_t xs, output int idx, output int val);
    idx = 0; val = 0;
    for (int j = 0; j < N_OUT; j++) begin
      int s;
      s = mb[j];
      for (int i = 0; i < N_IN; i++) s += xs[i] * mw[j][i];
`ifdef FC_RELU_EN
      if (s < 0) s = 0;
`endif
      if (j == 0 || s > val) begin val = s; idx = j; end
    end
  endfunction

  task automatic write_param(input bit sel, input int row, input int col, input int val);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_row = 2'(row); wr_col = 2'(col); wr_data = W_W'(val);
    @(negedge clk);
    wr_en = 1'b0;
    if (sel) mb[row] = val; else mw[row][col] = val;
  endtask

  task automatic load_params(input vec_t w0, input vec_t w1, input vec_t w2, input int b0,
                             input int b1, input int b2);
    for (int i = 0; i < N_IN; i++) begin
      write_param(0, 0, i, w0[i]);
      write_param(0, 1, i, w1[i]);
      write_param(0, 2, i, w2[i]);
    end
    write_param(1, 0, $urandom_range(0, 3), b0);
    write_param(1, 1, $urandom_range(0, 3), b1);
    write_param(1, 2, $urandom_range(0, 3), b2);
  endtask

  task automatic start_run(input bit with_wr, input int row, input int col, input int val);
    @(negedge clk);
    start = 1'b1;
    if (with_wr) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'(row); wr_col = 2'(col); wr_data = W_W'(val);
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    if (with_wr) mw[row][col] = val;
  endtask

  // Ends at the negedge where done is first seen (or after the bound expires).
  task automatic feed_and_wait(input vec_t xs, input bit stalls, output int lat,
                               output bit got_done, output logic ready_after);
    for (int i = 0; i < N_IN; i++) begin
      if (stalls) while ($urandom_range(0, 2) == 0) begin x_valid = 1'b0; @(negedge clk); end
      x_valid = 1'b1; x_data = X_W'(xs[i]);
      @(negedge clk);
    end
    x_valid = 1'b0;
    ready_after = x_ready;
    lat = 0; got_done = 1'b0;
    while (!got_done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) got_done = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (x_ready !== 1'b0) begin n_fail++; $display("FAIL reset_x_ready got %b want 0", x_ready); end
    n_checks++; if (result !== 2'd0) begin n_fail++; $display("FAIL reset_result got %0d want 0", result); end
    n_checks++; if (max_value !== 32'sd0) begin n_fail++; $display("FAIL reset_max got %0d want 0", max_value); end
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b want 0", result_valid); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_and_check(input string name, input vec_t xs, input bit stalls);
    int lat, ei, ev; bit got; logic rdy;
    model(xs, ei, ev);
    start_run(0, 0, 0, 0);
    feed_and_wait(xs, stalls, lat, got, rdy);
    n_checks++; if (!got) begin n_fail++; $display("FAIL %s_done_timeout got none want done", name); end
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL %s_latency got %0d want %0d", name, lat, LAT); end
    n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL %s_ready_after got %b want 0", name, rdy); end
    n_checks++; if (result !== 2'(ei)) begin n_fail++; $display("FAIL %s_result got %0d want %0d", name, result, ei); end
    n_checks++; if (max_value !== ACC_W'(ev)) begin n_fail++; $display("FAIL %s_max got %0d want %0d", name, max_value, ev); end
    n_checks++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL %s_rvalid got %b want 1", name, result_valid); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL %s_done_pulse got done=%b busy=%b want 0 0", name, done, busy); end
  endtask

  task automatic load_033();
    load_params('{1, 1, 1, 1}, '{2, 0, 0, 0}, '{-1, -1, -1, -1}, 0, 5, 0);
  endtask

  task automatic test_spec_vector();
    load_033();
    run_and_check("spec033", '{10, 20, 30, 40}, 0);
  endtask

  task automatic test_tie();
    load_params('{1, 0, 0, 0}, '{1, 0, 0, 0}, '{0, 0, 0, 0}, 0, 0, 0);
    run_and_check("tie", '{7, 0, 0, 0}, 0);
  endtask

  task automatic test_bias_only();
    load_params('{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, -5, -3, -7);
    run_and_check("bias_only", '{$urandom_range(0, 255), $urandom_range(0, 255),
                                 $urandom_range(0, 255), $urandom_range(0, 255)}, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      vec_t w0, w1, w2, xs;
      for (int i = 0; i < N_IN; i++) begin
        w0[i] = int'($urandom_range(0, 1023)) - 512;
        w1[i] = int'($urandom_range(0, 1023)) - 512;
        w2[i] = int'($urandom_range(0, 1023)) - 512;
        xs[i] = int'($urandom_range(0, 255));
      end
      load_params(w0, w1, w2, int'($urandom_range(0, 1023)) - 512,
                  int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512);
      run_and_check("random", xs, 1);
    end
  endtask

  task automatic test_write_with_start();
    vec_t xs;
    int lat, ei, ev; bit got; logic rdy;
    xs = '{3, 9, 255, 1};
    start_run(1, 1, 2, 511);
    model(xs, ei, ev);
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL start_clears_rvalid got %b want 0", result_valid); end
    feed_and_wait(xs, 1, lat, got, rdy);
    n_checks++; if (!got || result !== 2'(ei) || max_value !== ACC_W'(ev)) begin
      n_fail++; $display("FAIL wr_with_start got idx=%0d max=%0d want idx=%0d max=%0d", result, max_value, ei, ev);
    end
    repeat ($urandom_range(3, 8)) @(negedge clk);
    n_checks++; if (result !== 2'(ei) || max_value !== ACC_W'(ev) || result_valid !== 1'b1) begin
      n_fail++; $display("FAIL result_hold got idx=%0d max=%0d v=%b want idx=%0d max=%0d v=1", result, max_value, result_valid, ei, ev);
    end
  endtask

  task automatic test_busy_ignore();
    vec_t xs;
    int x6[6];
    int ei, ev, accepted, cyc; bit seen;
    logic [1:0] got_idx; logic signed [ACC_W-1:0] got_max;
    x6 = '{10, 20, 30, 40, 99, 99};
    xs = '{10, 20, 30, 40};
    load_033();
    model(xs, ei, ev);
    start_run(0, 0, 0, 0);
    accepted = 0; seen = 1'b0; cyc = 0; got_idx = '0; got_max = '0;
    while (!seen && cyc < 40) begin
      x_valid = (cyc < 12) && (cyc % 2 == 0);
      x_data  = (cyc < 12) ? X_W'(x6[cyc / 2]) : '0;
      start   = (cyc == 3 || cyc == 8);
      wr_en   = (cyc == 3 || cyc == 8);
      wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = -10'sd200;
      if (x_valid && x_ready) accepted++;
      @(negedge clk);
      cyc++;
      if (done) begin seen = 1'b1; got_idx = result; got_max = max_value; end
    end
    x_valid = 1'b0; start = 1'b0; wr_en = 1'b0;
    n_checks++; if (accepted != N_IN) begin n_fail++; $display("FAIL toggle_accepted got %0d want %0d", accepted, N_IN); end
    n_checks++; if (!seen || got_idx !== 2'(ei) || got_max !== ACC_W'(ev)) begin
      n_fail++; $display("FAIL toggle_result got done=%b idx=%0d max=%0d want idx=%0d max=%0d", seen, got_idx, got_max, ei, ev);
    end
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_ignored got %b want 0", busy); end
    run_and_check("after_busy_wr", xs, 0);
  endtask

  task automatic test_reset_midrun();
    bit seen;
    start_run(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      x_valid = 1'b1; x_data = X_W'(10 * (i + 1));
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || x_ready !== 1'b0 || result_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrun_reset got busy=%b rdy=%b v=%b want 0 0 0", busy, x_ready, result_valid);
    end
    @(negedge clk);
    x_valid = 1'b0;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin @(negedge clk); if (done) seen = 1'b1; end
    n_checks++; if (seen) begin n_fail++; $display("FAIL midrun_no_done got done pulse want none"); end
    run_and_check("rerun_after_reset", '{10, 20, 30, 40}, 1);
  endtask

  initial begin
    test_reset();
    test_spec_vector();
    test_tie();
    test_bias_only();
    test_random();
    test_write_with_start();
    test_busy_ignore();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got hang want finish");
    $fatal(1, "timeout");
  end
endmodule
